// File: rtl/id_ex_stage_reg_if.sv
// Decode-to-execute bundle: D-side fields and hazard controls driven by the master,
// registered E-side copies driven by the pipeline register (slave).
interface id_ex_stage_reg_if #(
    parameter int unsigned XLEN = 32
);
    logic            stallE;
    logic            flushE;

    logic            validD;
    logic [XLEN-1:0] pcD;
    logic [XLEN-1:0] pcplusD;
    logic [XLEN-1:0] rd1D;
    logic [XLEN-1:0] rd2D;
    logic [XLEN-1:0] immextD;
    logic [4:0]      Rs1D;
    logic [4:0]      Rs2D;
    logic [4:0]      RdD;
    logic            regwriteD;
    logic            memwriteD;
    logic            jumpD;
    logic            branchD;
    logic            alusrcD;
    logic [1:0]      resultsrcD;
    logic [2:0]      alucontrolD;

    logic            validE;
    logic [XLEN-1:0] pcE;
    logic [XLEN-1:0] pcplusE;
    logic [XLEN-1:0] rd1E;
    logic [XLEN-1:0] rd2E;
    logic [XLEN-1:0] immextE;
    logic [4:0]      Rs1E;
    logic [4:0]      Rs2E;
    logic [4:0]      RdE;
    logic            regwriteE;
    logic            memwriteE;
    logic            jumpE;
    logic            branchE;
    logic            alusrcE;
    logic [1:0]      resultsrcE;
    logic [2:0]      alucontrolE;

    modport master (
        output stallE, flushE,
        output validD, pcD, pcplusD, rd1D, rd2D, immextD, Rs1D, Rs2D, RdD,
        output regwriteD, memwriteD, jumpD, branchD, alusrcD, resultsrcD, alucontrolD,
        input  validE, pcE, pcplusE, rd1E, rd2E, immextE, Rs1E, Rs2E, RdE,
        input  regwriteE, memwriteE, jumpE, branchE, alusrcE, resultsrcE, alucontrolE
    );

    modport slave (
        input  stallE, flushE,
        input  validD, pcD, pcplusD, rd1D, rd2D, immextD, Rs1D, Rs2D, RdD,
        input  regwriteD, memwriteD, jumpD, branchD, alusrcD, resultsrcD, alucontrolD,
        output validE, pcE, pcplusE, rd1E, rd2E, immextE, Rs1E, Rs2E, RdE,
        output regwriteE, memwriteE, jumpE, branchE, alusrcE, resultsrcE, alucontrolE
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with flush-to-bubble, stall-hold and dead-slot masking.
// Define IDEX_PERF_CNT_EN to add bubble_cnt/stall_cnt performance counters.
module id_ex_stage_reg #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_stage_reg_if.slave bus
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    if (CNT_W == 0) begin : g_cnt_w_chk
        $error("CNT_W must be at least 1");
    end

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] immext;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            regwrite;
        logic            memwrite;
        logic            jump;
        logic            branch;
        logic            alusrc;
        logic [1:0]      resultsrc;
        logic [2:0]      alucontrol;
    } stage_t;

    stage_t load_d;
    stage_t stage_d;
    stage_t stage_q;

    always_comb begin
        load_d.valid      = bus.validD;
        load_d.pc         = bus.pcD;
        load_d.pcplus     = bus.pcplusD;
        load_d.rd1        = bus.rd1D;
        load_d.rd2        = bus.rd2D;
        load_d.immext     = bus.immextD;
        load_d.rs1        = bus.Rs1D;
        load_d.rs2        = bus.Rs2D;
        load_d.rd         = bus.RdD;
        load_d.regwrite   = bus.regwriteD;
        load_d.memwrite   = bus.memwriteD;
        load_d.jump       = bus.jumpD;
        load_d.branch     = bus.branchD;
        load_d.alusrc     = bus.alusrcD;
        load_d.resultsrc  = bus.resultsrcD;
        load_d.alucontrol = bus.alucontrolD;
        // A dead slot must never write state nor look like a load to the hazard unit.
        if (!bus.validD) begin
            load_d.regwrite     = 1'b0;
            load_d.memwrite     = 1'b0;
            load_d.jump         = 1'b0;
            load_d.branch       = 1'b0;
            load_d.rd           = 5'd0;
            load_d.resultsrc[0] = 1'b0;
        end
    end

    always_comb begin
        stage_d = stage_q;
        if (bus.flushE) begin
            stage_d = '0;
        end else if (!bus.stallE) begin
            stage_d = load_d;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W - 1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] bubble_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (bus.flushE || (!bus.stallE && !bus.validD)) begin
            bubble_cnt_d = bubble_cnt_q + CntOne;
        end
        if (bus.stallE && !bus.flushE) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q      <= '0;
`ifdef IDEX_PERF_CNT_EN
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
`endif
        end else begin
            stage_q      <= stage_d;
`ifdef IDEX_PERF_CNT_EN
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
`endif
        end
    end

    assign bus.validE      = stage_q.valid;
    assign bus.pcE         = stage_q.pc;
    assign bus.pcplusE     = stage_q.pcplus;
    assign bus.rd1E        = stage_q.rd1;
    assign bus.rd2E        = stage_q.rd2;
    assign bus.immextE     = stage_q.immext;
    assign bus.Rs1E        = stage_q.rs1;
    assign bus.Rs2E        = stage_q.rs2;
    assign bus.RdE         = stage_q.rd;
    assign bus.regwriteE   = stage_q.regwrite;
    assign bus.memwriteE   = stage_q.memwrite;
    assign bus.jumpE       = stage_q.jump;
    assign bus.branchE     = stage_q.branch;
    assign bus.alusrcE     = stage_q.alusrc;
    assign bus.resultsrcE  = stage_q.resultsrc;
    assign bus.alucontrolE = stage_q.alucontrol;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed plan steps plus random traffic
// against a field-level reference model; counters checked when IDEX_PERF_CNT_EN is set.
module tb_id_ex_stage_reg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;
    localparam int          CNT_M = 16;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] immext;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            regwrite;
        logic            memwrite;
        logic            jump;
        logic            branch;
        logic            alusrc;
        logic [1:0]      resultsrc;
        logic [2:0]      alucontrol;
    } e_t;

    logic clk;
    logic rst_n;
    id_ex_stage_reg_if #(.XLEN(XLEN)) bus ();

`ifdef IDEX_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] stall_cnt;
`endif

    id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave)
`ifdef IDEX_PERF_CNT_EN
        ,
        .bubble_cnt (bubble_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    e_t   exp_e;
    int   exp_bub;
    int   exp_stl;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic e_t observe();
        e_t r;
        r.valid      = bus.validE;
        r.pc         = bus.pcE;
        r.pcplus     = bus.pcplusE;
        r.rd1        = bus.rd1E;
        r.rd2        = bus.rd2E;
        r.immext     = bus.immextE;
        r.rs1        = bus.Rs1E;
        r.rs2        = bus.Rs2E;
        r.rd         = bus.RdE;
        r.regwrite   = bus.regwriteE;
        r.memwrite   = bus.memwriteE;
        r.jump       = bus.jumpE;
        r.branch     = bus.branchE;
        r.alusrc     = bus.alusrcE;
        r.resultsrc  = bus.resultsrcE;
        r.alucontrol = bus.alucontrolE;
        return r;
    endfunction

    // Reference: what the execute slot should hold after one edge, from the stated rules.
    function automatic e_t model_next(input e_t cur, input logic fl, input logic st);
        e_t r;
        if (fl) return '0;
        if (st) return cur;
        r = '{valid: bus.validD, pc: bus.pcD, pcplus: bus.pcplusD, rd1: bus.rd1D,
              rd2: bus.rd2D, immext: bus.immextD, rs1: bus.Rs1D, rs2: bus.Rs2D, rd: bus.RdD,
              regwrite: bus.regwriteD, memwrite: bus.memwriteD, jump: bus.jumpD,
              branch: bus.branchD, alusrc: bus.alusrcD, resultsrc: bus.resultsrcD,
              alucontrol: bus.alucontrolD};
        if (!bus.validD) begin
            r.regwrite = 0; r.memwrite = 0; r.jump = 0; r.branch = 0;
            r.rd = 0; r.resultsrc[0] = 0;
        end
        return r;
    endfunction

    task automatic rand_d(input int valid_pct);
        bus.validD      = ($urandom_range(99) < valid_pct);
        bus.pcD         = $urandom;
        bus.pcplusD     = $urandom;
        bus.rd1D        = $urandom;
        bus.rd2D        = $urandom;
        bus.immextD     = $urandom;
        bus.Rs1D        = 5'($urandom);
        bus.Rs2D        = 5'($urandom);
        bus.RdD         = 5'($urandom);
        bus.regwriteD   = 1'($urandom);
        bus.memwriteD   = 1'($urandom);
        bus.jumpD       = 1'($urandom);
        bus.branchD     = 1'($urandom);
        bus.alusrcD     = 1'($urandom);
        bus.resultsrcD  = 2'($urandom);
        bus.alucontrolD = 3'($urandom);
    endtask

    task automatic check_counters(input string tag);
`ifdef IDEX_PERF_CNT_EN
        check({tag, "_bubble_cnt"}, 256'(bubble_cnt), 256'(exp_bub));
        check({tag, "_stall_cnt"}, 256'(stall_cnt), 256'(exp_stl));
`else
        if (tag.len() == 0) $display("note: empty tag");
`endif
    endtask

    task automatic step(input logic fl, input logic st, input string tag);
        e_t nxt;
        bit bub;
        bus.flushE = fl;
        bus.stallE = st;
        nxt = model_next(exp_e, fl, st);
        bub = fl || (!st && !bus.validD);
        @(posedge clk);
        #1;
        exp_e = nxt;
        if (bub) exp_bub = (exp_bub + 1) % CNT_M;
        if (st && !fl) exp_stl = (exp_stl + 1) % CNT_M;
        bus.flushE = 0;
        bus.stallE = 0;
        check({tag, "_estate"}, 256'(observe()), 256'(exp_e));
        check_counters(tag);
    endtask

    // Asserts reset between edges and checks that outputs clear without a clock edge.
    task automatic pulse_reset(input string tag);
        #3;
        rst_n = 0;
        #1;
        exp_e = '0;
        exp_bub = 0;
        exp_stl = 0;
        check({tag, "_estate"}, 256'(observe()), 256'(exp_e));
        check_counters(tag);
        #1;
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        bus.flushE = 0;
        bus.stallE = 0;
        rand_d(100);
        bus.validD = 0;
        exp_e = '0;
        exp_bub = 0;
        exp_stl = 0;
        #2;
        check("reset_estate", 256'(observe()), 256'(exp_e));
        check_counters("reset");
        #10;
        rst_n = 1;

        // Reset mid-stream.
        rand_d(100);
        bus.validD = 1; bus.RdD = 5'd5; bus.regwriteD = 1;
        step(0, 0, "rs_load");
        check("rs_load_rd", 256'(bus.RdE), 256'(5));
        pulse_reset("rs_async");
        rand_d(100);
        bus.validD = 0;
        step(0, 0, "rs_dead");
        check("rs_dead_valid", 256'(bus.validE), 256'(0));
        check("rs_dead_rd", 256'(bus.RdE), 256'(0));

        // Straight load.
        rand_d(100);
        bus.validD = 1; bus.pcD = 32'h100; bus.RdD = 5'd7;
        bus.resultsrcD = 2'b01; bus.immextD = 32'hFFFF_FFF0;
        step(0, 0, "load");
        check("load_pc", 256'(bus.pcE), 256'(32'h100));
        check("load_rd", 256'(bus.RdE), 256'(7));
        check("load_rsrc", 256'(bus.resultsrcE), 256'(2'b01));
        check("load_imm", 256'(bus.immextE), 256'(32'hFFFF_FFF0));
        check("load_valid", 256'(bus.validE), 256'(1));

        // Flush pulse, then resume loading.
        rand_d(100);
        bus.validD = 1; bus.RdD = 5'd3; bus.regwriteD = 1;
        step(0, 0, "fl_pre");
        rand_d(100);
        bus.validD = 1; bus.resultsrcD = 2'b11;
        step(1, 0, "flush");
        check("flush_rd", 256'(bus.RdE), 256'(0));
        check("flush_regwrite", 256'(bus.regwriteE), 256'(0));
        check("flush_valid", 256'(bus.validE), 256'(0));
        check("flush_rsrc", 256'(bus.resultsrcE), 256'(0));
        step(0, 0, "fl_post");

        // Stall hold for three edges while D changes.
        for (int i = 0; i < 3; i++) begin
            rand_d(75);
            step(0, 1, "stall");
        end
        rand_d(100);
        step(0, 0, "stall_rel");

        // Simultaneous flush and stall.
        rand_d(100);
        step(1, 1, "fl_st");
        check("fl_st_valid", 256'(bus.validE), 256'(0));

        // Dead slot.
        rand_d(100);
        bus.validD = 0; bus.regwriteD = 1; bus.memwriteD = 1; bus.RdD = 5'd9;
        step(0, 0, "dead");
        check("dead_valid", 256'(bus.validE), 256'(0));
        check("dead_regwrite", 256'(bus.regwriteE), 256'(0));
        check("dead_memwrite", 256'(bus.memwriteE), 256'(0));
        check("dead_rd", 256'(bus.RdE), 256'(0));

        // Sixteen bubbles from reset wrap a 4-bit counter.
        pulse_reset("wrap_rst");
        for (int i = 0; i < 16; i++) begin
            rand_d(100);
            step(1, 0, "wrap");
        end
`ifdef IDEX_PERF_CNT_EN
        check("wrap_zero", 256'(bubble_cnt), 256'(0));
`endif

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            rand_d(75);
            step(($urandom_range(7) == 0), ($urandom_range(3) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
